// File: rtl/ic_signal_fsm.sv
// ic_signal_fsm: Ichimoku-cloud trade signal generator.
// Takes one sample per valid/ready handshake. Stage 1 registers the float
// comparisons. Stage 2 classifies the sample, filters the class through a
// confirmation run counter and steps a FLAT/LONG/COOL position machine.
// The result is one registered trade action per sample, with backpressure.
module ic_signal_fsm #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned CONFIRM  = 3,
  parameter int unsigned COOLDOWN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] PRICE,
  input  logic [WIDTH-1:0] SSA,
  input  logic [WIDTH-1:0] SSB,
  input  logic [WIDTH-1:0] KS,
  input  logic [WIDTH-1:0] TS,
  output logic             sig_valid,
  input  logic             out_ready,
  output logic             act_buy,
  output logic             act_hold,
  output logic [1:0]       position,
  output logic [15:0]      trade_count
);

  localparam int unsigned MAN_W  = WIDTH - 1 - EXP_W;
  localparam int unsigned RUN_W  = $clog2(CONFIRM + 1);
  localparam int unsigned COOL_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  // Comparator result bit positions
  localparam int unsigned C_SSA_P   = 0;
  localparam int unsigned C_SSB_P   = 1;
  localparam int unsigned C_SSB_SSA = 2;
  localparam int unsigned C_KS_P    = 3;
  localparam int unsigned C_KS_TS   = 4;
  localparam int unsigned C_SSA_SSB = 5;
  localparam int unsigned C_P_KS    = 6;
  localparam int unsigned C_TS_KS   = 7;
  localparam int unsigned N_CMP     = 8;

  // Position states (also the encoding driven on the position port)
  localparam logic [1:0] ST_FLAT = 2'd0;
  localparam logic [1:0] ST_LONG = 2'd1;
  localparam logic [1:0] ST_COOL = 2'd2;

  // Raw sample classes
  localparam logic [1:0] CLS_HOLD = 2'd0;
  localparam logic [1:0] CLS_BUY  = 2'd1;
  localparam logic [1:0] CLS_SELL = 2'd2;

  // Strict IEEE a > b: NaN operands never compare, and signed zeros are equal.
  function automatic logic fgt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic             a_nan;
    logic             b_nan;
    logic [WIDTH-2:0] a_mag;
    logic [WIDTH-2:0] b_mag;
    logic             res;
    a_mag = a[WIDTH-2:0];
    b_mag = b[WIDTH-2:0];
    a_nan = (&a[WIDTH-2 -: EXP_W]) && (|a[MAN_W-1:0]);
    b_nan = (&b[WIDTH-2 -: EXP_W]) && (|b[MAN_W-1:0]);
    if (a_nan || b_nan) begin
      res = 1'b0;
    end else if ((a_mag == '0) && (b_mag == '0)) begin
      res = 1'b0;
    end else if (a[WIDTH-1] != b[WIDTH-1]) begin
      res = !a[WIDTH-1];
    end else if (!a[WIDTH-1]) begin
      res = a_mag > b_mag;
    end else begin
      res = a_mag < b_mag;
    end
    return res;
  endfunction

  logic             advance_c;
  logic [N_CMP-1:0] cmp_c;
  logic             s1_valid;
  logic [N_CMP-1:0] s1_cmp;

  logic             sell_c;
  logic             buy_c;
  logic [1:0]       raw_cls_c;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_nxt_c;
  logic             confirmed_c;
  logic [1:0]       prev_cls;

  logic [COOL_W-1:0] cool_cnt;
  logic [COOL_W-1:0] cool_inc_c;
  logic [COOL_W-1:0] cool_nxt_c;
  logic [1:0]        state_nxt_c;
  logic              buy_nxt_c;
  logic              hold_nxt_c;
  logic [15:0]       tc_nxt_c;

  // Both stages move together; a held result freezes the whole pipe
  assign advance_c = !sig_valid || out_ready;
  assign in_ready  = advance_c;

  // Stage-1 comparator bank on the incoming operands
  always_comb begin
    cmp_c            = '0;
    cmp_c[C_SSA_P]   = fgt(SSA, PRICE);
    cmp_c[C_SSB_P]   = fgt(SSB, PRICE);
    cmp_c[C_SSB_SSA] = fgt(SSB, SSA);
    cmp_c[C_KS_P]    = fgt(KS, PRICE);
    cmp_c[C_KS_TS]   = fgt(KS, TS);
    cmp_c[C_SSA_SSB] = fgt(SSA, SSB);
    cmp_c[C_P_KS]    = fgt(PRICE, KS);
    cmp_c[C_TS_KS]   = fgt(TS, KS);
  end

  // Stage-1 register: comparator results plus occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cmp   <= '0;
    end else if (advance_c) begin
      s1_valid <= in_valid;
      s1_cmp   <= cmp_c;
    end
  end

  // Raw cloud class (sell wins) and confirmation run update
  always_comb begin
    sell_c = (s1_cmp[C_SSA_P] && s1_cmp[C_SSB_P]) || s1_cmp[C_SSB_SSA] ||
             s1_cmp[C_KS_P] || s1_cmp[C_KS_TS];
    buy_c  = !(s1_cmp[C_SSA_P] || s1_cmp[C_SSB_P]) || s1_cmp[C_SSA_SSB] ||
             s1_cmp[C_P_KS] || s1_cmp[C_TS_KS];
    raw_cls_c = CLS_HOLD;
    if (sell_c) begin
      raw_cls_c = CLS_SELL;
    end else if (buy_c) begin
      raw_cls_c = CLS_BUY;
    end
    run_nxt_c = RUN_W'(1);
    if (raw_cls_c == prev_cls) begin
      run_nxt_c = (run_cnt == RUN_W'(CONFIRM)) ? run_cnt : run_cnt + RUN_W'(1);
    end
    confirmed_c = (run_nxt_c == RUN_W'(CONFIRM));
  end

  // Position next-state and action decode
  always_comb begin
    state_nxt_c = position;
    cool_nxt_c  = cool_cnt;
    cool_inc_c  = cool_cnt + COOL_W'(1);
    buy_nxt_c   = 1'b0;
    hold_nxt_c  = 1'b1;
    tc_nxt_c    = trade_count;
    case (position)
      ST_FLAT: begin
        if (confirmed_c && (raw_cls_c == CLS_BUY)) begin
          state_nxt_c = ST_LONG;
          buy_nxt_c   = 1'b1;
          hold_nxt_c  = 1'b0;
          tc_nxt_c    = trade_count + 16'd1;
        end
      end
      ST_LONG: begin
        if (confirmed_c && (raw_cls_c == CLS_SELL)) begin
          state_nxt_c = (COOLDOWN == 0) ? ST_FLAT : ST_COOL;
          cool_nxt_c  = '0;
          hold_nxt_c  = 1'b0;
          tc_nxt_c    = trade_count + 16'd1;
        end
      end
      ST_COOL: begin
        if (cool_inc_c == COOL_W'(COOLDOWN)) begin
          state_nxt_c = ST_FLAT;
          cool_nxt_c  = '0;
        end else begin
          cool_nxt_c  = cool_inc_c;
        end
      end
      default: begin
        state_nxt_c = ST_FLAT;
        cool_nxt_c  = '0;
      end
    endcase
  end

  // Position state register; bubbles leave it untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      position <= ST_FLAT;
      cool_cnt <= '0;
    end else if (advance_c && s1_valid) begin
      position <= state_nxt_c;
      cool_cnt <= cool_nxt_c;
    end
  end

  // Stage-2 result, confirmation history and trade counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_valid   <= 1'b0;
      act_buy     <= 1'b0;
      act_hold    <= 1'b1;
      trade_count <= '0;
      run_cnt     <= '0;
      prev_cls    <= CLS_HOLD;
    end else if (advance_c) begin
      sig_valid <= s1_valid;
      if (s1_valid) begin
        act_buy     <= buy_nxt_c;
        act_hold    <= hold_nxt_c;
        trade_count <= tc_nxt_c;
        run_cnt     <= run_nxt_c;
        prev_cls    <= raw_cls_c;
      end
    end
  end

endmodule

// File: tb/tb_ic_signal_fsm.sv
// Bench for ic_signal_fsm: directed scenarios plus randomized traffic,
// checked against a per-sample reference model and a handshake timing model.
module tb_ic_signal_fsm;

  localparam int unsigned CONF = 3;
  localparam int unsigned COOL = 8;

  localparam logic [31:0] F30   = 32'h41F00000;
  localparam logic [31:0] F40   = 32'h42200000;
  localparam logic [31:0] F50   = 32'h42480000;
  localparam logic [31:0] F60   = 32'h42700000;
  localparam logic [31:0] FNAN  = 32'h7FC00000;
  localparam logic [31:0] PZERO = 32'h00000000;
  localparam logic [31:0] NZERO = 32'h80000000;
  localparam logic [31:0] FN40  = 32'hC2200000;
  localparam logic [31:0] PINF  = 32'h7F800000;
  localparam logic [31:0] FDEN  = 32'h00000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] price, ssa, ssb, ks, ts;
  logic        sig_valid;
  logic        out_ready;
  logic        act_buy;
  logic        act_hold;
  logic [1:0]  position;
  logic [15:0] trade_count;

  always #5 clk = ~clk;

  ic_signal_fsm #(.WIDTH(32), .EXP_W(8), .CONFIRM(CONF), .COOLDOWN(COOL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .PRICE(price), .SSA(ssa), .SSB(ssb), .KS(ks), .TS(ts),
    .sig_valid(sig_valid), .out_ready(out_ready),
    .act_buy(act_buy), .act_hold(act_hold),
    .position(position), .trade_count(trade_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        buy;
    logic        hold;
    logic [1:0]  pos;
    logic [15:0] tc;
  } exp_t;

  exp_t q[$];
  bit   m_s1, m_sv;
  int   m_prev, m_run, m_pos, m_cool, m_tc;

  // classes: 0 hold, 1 buy, 2 sell; positions: 0 flat, 1 long, 2 cool
  function automatic bit is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [31:0] b);
    int  e  = int'(b[30:23]);
    int  mi = int'(b[22:0]);
    real m  = mi / 8388608.0;
    real r;
    if (e == 255)    r = 1.0e300;
    else if (e == 0) r = m * pow2(-126);
    else             r = (1.0 + m) * pow2(e - 127);
    return b[31] ? -r : r;
  endfunction

  function automatic bit gtm(input logic [31:0] a, input logic [31:0] b);
    if (is_nan(a) || is_nan(b)) return 1'b0;
    return f2r(a) > f2r(b);
  endfunction

  function automatic int classify(input logic [31:0] p, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] k,
                                  input logic [31:0] t);
    if ((gtm(a, p) && gtm(b, p)) || gtm(b, a) || gtm(k, p) || gtm(k, t)) return 2;
    if (!(gtm(a, p) || gtm(b, p)) || gtm(a, b) || gtm(p, k) || gtm(t, k)) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_s1 = 0; m_sv = 0;
    m_prev = 0; m_run = 0; m_pos = 0; m_cool = 0; m_tc = 0;
  endtask

  task automatic model_accept(input logic [31:0] p, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] k,
                              input logic [31:0] t);
    int   cls;
    bit   conf;
    exp_t e;
    cls = classify(p, a, b, k, t);
    if (cls == m_prev) m_run = (m_run < int'(CONF)) ? m_run + 1 : int'(CONF);
    else               m_run = 1;
    m_prev = cls;
    conf   = (m_run == int'(CONF));
    e.buy  = 1'b0;
    e.hold = 1'b1;
    if (m_pos == 0) begin
      if (conf && cls == 1) begin
        m_pos = 1; e.buy = 1'b1; e.hold = 1'b0; m_tc++;
      end
    end else if (m_pos == 1) begin
      if (conf && cls == 2) begin
        e.hold = 1'b0; m_tc++; m_cool = 0;
        m_pos = (COOL > 0) ? 2 : 0;
      end
    end else begin
      m_cool++;
      if (m_cool >= int'(COOL)) begin
        m_pos = 0; m_cool = 0;
      end
    end
    e.pos = 2'(m_pos);
    e.tc  = 16'(m_tc);
    q.push_back(e);
  endtask

  task automatic check_outputs();
    check("sig_valid", sig_valid, m_sv);
    if (m_sv && q.size() > 0) begin
      check("act_buy", act_buy, q[0].buy);
      check("act_hold", act_hold, q[0].hold);
      check("position", position, q[0].pos);
      check("trade_count", trade_count, q[0].tc);
    end
  endtask

  // One clock: drive at negedge, update models at posedge, check at next negedge
  task automatic step(input bit v, input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] k,
                      input logic [31:0] t, input bit ordy);
    bit adv;
    in_valid = v; price = p; ssa = a; ssb = b; ks = k; ts = t;
    out_ready = ordy;
    adv = !m_sv || ordy;
    #1;
    check("in_ready", in_ready, adv);
    @(posedge clk);
    if (adv) begin
      if (m_sv && q.size() > 0) q.delete(0);
      m_sv = m_s1;
      m_s1 = v;
      if (v) model_accept(p, a, b, k, t);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    check("rst_sig_valid", sig_valid, 0);
    check("rst_act_buy", act_buy, 0);
    check("rst_act_hold", act_hold, 1);
    check("rst_position", position, 0);
    check("rst_trade_count", trade_count, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
  endtask

  task automatic s_buy(input bit ordy);
    step(1, F50, F40, F30, F40, F60, ordy);
  endtask
  task automatic s_sell();
    step(1, F30, F50, F40, F40, F40, 1);
  endtask
  task automatic s_idle();
    step(0, PZERO, PZERO, PZERO, PZERO, PZERO, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] pool [10];
  logic [31:0] o [5];
  int          tmpl;
  int          runleft;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    pool[0] = F30;  pool[1] = F40;  pool[2] = F50;  pool[3] = F60;  pool[4] = PZERO;
    pool[5] = NZERO; pool[6] = FNAN; pool[7] = FN40; pool[8] = PINF; pool[9] = FDEN;
    model_reset();
    do_reset();

    // buy entry with latency
    s_buy(1);
    check("lat_sv_t1", sig_valid, 0);
    s_buy(1);
    check("lat_sv_t2", sig_valid, 1);
    check("entry_hold1", act_hold, 1);
    s_buy(1);
    check("entry_hold2", act_hold, 1);
    s_idle();
    check("entry_buy", act_buy, 1);
    check("entry_long", position, 1);
    check("entry_tc", trade_count, 1);

    // sell exit, cooldown fed with buys, then immediate re-entry
    repeat (3) s_sell();
    s_idle();
    check("exit_sell", {act_buy, act_hold}, 2'b00);
    check("exit_cool", position, 2);
    check("exit_tc", trade_count, 2);
    repeat (7) s_buy(1);
    s_idle();
    check("cool7_pos", position, 2);
    s_buy(1);
    s_idle();
    check("cool8_flat", position, 0);
    check("cool8_hold", act_hold, 1);
    s_buy(1);
    s_idle();
    check("reentry_buy", act_buy, 1);
    check("reentry_tc", trade_count, 3);

    // broken run
    do_reset();
    s_buy(1); s_buy(1); s_sell(); s_buy(1); s_buy(1);
    s_idle();
    check("broken5_flat", position, 0);
    check("broken5_tc", trade_count, 0);
    s_buy(1);
    s_idle();
    check("broken6_buy", act_buy, 1);
    check("broken6_long", position, 1);

    // backpressure
    do_reset();
    s_buy(1); s_buy(1);
    for (int i = 0; i < 5; i++) begin
      s_buy(0);
      check("bp_in_ready", in_ready, 0);
      check("bp_act_hold", act_hold, 1);
    end
    s_buy(1); s_buy(1); s_buy(1);
    s_idle();
    check("bp_release_tc", trade_count, 1);
    s_idle();

    // NaN price and signed zeros
    do_reset();
    repeat (3) step(1, FNAN, F40, F30, F40, F60, 1);
    s_idle();
    check("nan_buy", act_buy, 1);
    do_reset();
    repeat (3) step(1, F50, NZERO, PZERO, F40, F60, 1);
    s_idle();
    check("zero_buy", act_buy, 1);
    do_reset();
    repeat (3) step(1, F50, FNAN, F60, F50, F50, 1);
    s_idle();
    check("nan_hold", act_hold, 1);
    check("nan_hold_flat", position, 0);

    // reset with two samples in flight, then counters restart
    do_reset();
    s_buy(1); s_buy(1);
    do_reset();
    s_buy(1); s_buy(1);
    s_idle();
    check("restart_no_buy", act_buy, 0);
    s_buy(1);
    s_idle();
    check("restart_buy", act_buy, 1);

    // randomized traffic
    runleft = 0;
    tmpl    = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      if (runleft == 0) begin
        tmpl    = int'($urandom_range(0, 3));
        runleft = int'($urandom_range(1, 6));
      end
      case (tmpl)
        0: begin o[0] = F50; o[1] = F40;  o[2] = F30; o[3] = F40; o[4] = F60; end
        1: begin o[0] = F30; o[1] = F50;  o[2] = F40; o[3] = F40; o[4] = F40; end
        2: for (int j = 0; j < 5; j++) o[j] = pool[$urandom_range(0, 9)];
        default: begin o[0] = F50; o[1] = FNAN; o[2] = F60; o[3] = F50; o[4] = F50; end
      endcase
      if ($urandom_range(0, 9) < 7) begin
        step(1, o[0], o[1], o[2], o[3], o[4], $urandom_range(0, 9) < 7);
        runleft--;
      end else begin
        step(0, o[0], o[1], o[2], o[3], o[4], $urandom_range(0, 9) < 7);
      end
    end
    repeat (4) s_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
